// File: rtl/polyphase_commutator.sv
// Polyphase filter-bank commutator on one fabric clock with enable strobes.
// Mode 0 serialises N branch outputs; mode 1 gathers a stream into N slots.
module polyphase_commutator #(
  parameter int gp_idata_width = 26,
  parameter int gp_nchan       = 32,
  parameter int gp_mode        = 0,
  parameter int gp_ccw         = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_an,
  input  logic                                 i_ena,
  input  logic                                 i_sync,
  input  logic                                 i_ccw,
  input  logic [gp_nchan*gp_idata_width-1:0]   i_data_par,
  input  logic [gp_idata_width-1:0]            i_data_ser,
  output logic [gp_idata_width-1:0]            o_data_ser,
  output logic [gp_nchan*gp_idata_width-1:0]   o_data_par,
  output logic [$clog2(gp_nchan)-1:0]          o_idx,
  output logic                                 o_valid,
  output logic                                 o_frame
);

  localparam int W  = gp_idata_width;
  localparam int N  = gp_nchan;
  localparam int IW = $clog2(N);
  localparam int PW = N * W;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] cnt;
  logic [IW-1:0] sel;
  logic          dir;
  logic          eff_ccw;
  logic          step;
  logic          fstart;
  logic          last;
  logic [PW-1:0] shadow;

  assign step    = i_ena & ~i_sync;
  assign fstart  = step & (cnt == '0);
  assign last    = (cnt == LAST);
  // The frame-start step already follows the newly requested direction.
  assign eff_ccw = fstart ? i_ccw : dir;
  assign sel     = eff_ccw ? cnt : LAST - cnt;

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      cnt <= '0;
      dir <= (gp_ccw != 0);
    end else if (i_sync) begin
      cnt <= '0;
    end else if (i_ena) begin
      cnt <= last ? '0 : cnt + IW'(1);
      if (fstart) dir <= i_ccw;
    end
  end

  if (gp_mode == 0) begin : g_interp
    logic [W-1:0] par_pick;
    logic [W-1:0] sh_pick;
    logic         unused_ser;

    assign unused_ser = ^i_data_ser;

    always_comb begin
      par_pick = '0;
      sh_pick  = '0;
      for (int c = 0; c < N; c++) begin
        if (sel == IW'(c)) begin
          par_pick = i_data_par[c*W +: W];
          sh_pick  = shadow[c*W +: W];
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
        shadow     <= '0;
        o_data_ser <= '0;
        o_idx      <= '0;
        o_valid    <= 1'b0;
        o_frame    <= 1'b0;
      end else begin
        o_valid <= step;
        o_frame <= fstart;
        if (step) begin
          o_idx      <= sel;
          o_data_ser <= fstart ? par_pick : sh_pick;
          if (fstart) shadow <= i_data_par;
        end
      end
    end

    assign o_data_par = '0;
  end else begin : g_decim
    logic [PW-1:0] nxt;
    logic          unused_par;

    assign unused_par = ^i_data_par;

    always_comb begin
      nxt = shadow;
      for (int c = 0; c < N; c++) begin
        if (sel == IW'(c)) nxt[c*W +: W] = i_data_ser;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
        shadow     <= '0;
        o_data_par <= '0;
        o_idx      <= '0;
        o_valid    <= 1'b0;
        o_frame    <= 1'b0;
      end else begin
        o_valid <= step & last;
        o_frame <= step & last;
        if (step) begin
          shadow <= nxt;
          o_idx  <= sel;
          if (last) o_data_par <= nxt;
        end
      end
    end

    assign o_data_ser = '0;
  end

endmodule

// File: tb/tb_polyphase_commutator.sv
// Scoreboard bench: mode 0 with N=4 and N=3, mode 1 with N=4.
// A frame-level model pushes expectations; monitors pop on o_valid.
module tb_polyphase_commutator;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ena = 1'b0;
  logic sync = 1'b0;
  logic ccw = 1'b1;
  logic [31:0] a_par = '0;
  logic [23:0] c_par = '0;
  logic [7:0]  b_ser = '0;

  logic [7:0]  a_ser, b_oser, c_ser;
  logic [31:0] a_ppar, b_par;
  logic [23:0] c_ppar;
  logic [1:0]  a_idx, b_idx, c_idx;
  logic        a_valid, a_frame, b_valid, b_frame, c_valid, c_frame;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  polyphase_commutator #(
    .gp_idata_width(8), .gp_nchan(4), .gp_mode(0), .gp_ccw(1)
  ) u_a (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sync(sync),
    .i_ccw(ccw), .i_data_par(a_par), .i_data_ser(b_ser),
    .o_data_ser(a_ser), .o_data_par(a_ppar), .o_idx(a_idx),
    .o_valid(a_valid), .o_frame(a_frame)
  );

  polyphase_commutator #(
    .gp_idata_width(8), .gp_nchan(4), .gp_mode(1), .gp_ccw(1)
  ) u_b (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sync(sync),
    .i_ccw(ccw), .i_data_par(a_par), .i_data_ser(b_ser),
    .o_data_ser(b_oser), .o_data_par(b_par), .o_idx(b_idx),
    .o_valid(b_valid), .o_frame(b_frame)
  );

  polyphase_commutator #(
    .gp_idata_width(8), .gp_nchan(3), .gp_mode(0), .gp_ccw(0)
  ) u_c (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sync(sync),
    .i_ccw(ccw), .i_data_par(c_par), .i_data_ser(b_ser),
    .o_data_ser(c_ser), .o_data_par(c_ppar), .o_idx(c_idx),
    .o_valid(c_valid), .o_frame(c_frame)
  );

  // reference model state: position in frame, latched direction
  int pa = 0, pb = 0, pc = 0;
  bit da = 1'b1, db = 1'b1, dc = 1'b0;
  logic [31:0] snap_a = '0;
  logic [23:0] snap_c = '0;
  logic [7:0]  fb [4];
  logic [10:0] qa [$];
  logic [10:0] qc [$];
  logic [33:0] qb [$];
  logic [7:0]  la = '0, lc = '0;
  logic [31:0] lb = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model();
    int ch;
    if (sync) begin
      pa = 0; pb = 0; pc = 0;
      return;
    end
    if (!ena) return;
    if (pa == 0) begin snap_a = a_par; da = ccw; end
    ch = da ? pa : 3 - pa;
    qa.push_back({pa == 0, 2'(ch), snap_a[ch*8 +: 8]});
    pa = (pa + 1) % 4;
    if (pc == 0) begin snap_c = c_par; dc = ccw; end
    ch = dc ? pc : 2 - pc;
    qc.push_back({pc == 0, 2'(ch), snap_c[ch*8 +: 8]});
    pc = (pc + 1) % 3;
    if (pb == 0) db = ccw;
    ch = db ? pb : 3 - pb;
    fb[ch] = b_ser;
    pb++;
    if (pb == 4) begin
      qb.push_back({2'(ch), fb[3], fb[2], fb[1], fb[0]});
      pb = 0;
    end
  endtask

  task automatic drive(input logic e, input logic s, input logic d,
                       input logic [31:0] ap, input logic [23:0] cp,
                       input logic [7:0] bs);
    @(posedge clk);
    #1;
    ena = e; sync = s; ccw = d;
    a_par = ap; c_par = cp; b_ser = bs;
    model();
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_a"}, {a_ser, a_idx, a_valid, a_frame, a_ppar}, '0);
    chk({tag, "_b"}, {b_oser, b_idx, b_valid, b_frame, b_par}, '0);
    chk({tag, "_c"}, {c_ser, c_idx, c_valid, c_frame, c_ppar}, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; ena = 1'b0; sync = 1'b0;
    #1;
    zero_chk("rst_mid");
    qa.delete(); qb.delete(); qc.delete();
    pa = 0; pb = 0; pc = 0;
    da = 1'b1; db = 1'b1; dc = 1'b0;
    la = '0; lb = '0; lc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : mon_a
    logic [10:0] e;
    if (rst_n) begin
      if (a_valid) begin
        if (qa.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL a_spurious act=valid exp=idle t=%0t", $time);
        end else begin
          e = qa.pop_front();
          chk("a_out", {a_frame, a_idx, a_ser}, e);
          la = e[7:0];
        end
      end else begin
        chk("a_hold", {a_frame, a_ser}, {1'b0, la});
      end
    end
  end

  always @(negedge clk) begin : mon_c
    logic [10:0] e;
    if (rst_n) begin
      if (c_valid) begin
        if (qc.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL c_spurious act=valid exp=idle t=%0t", $time);
        end else begin
          e = qc.pop_front();
          chk("c_out", {c_frame, c_idx, c_ser}, e);
          lc = e[7:0];
        end
      end else begin
        chk("c_hold", {c_frame, c_ser}, {1'b0, lc});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [33:0] e;
    if (rst_n) begin
      if (b_valid) begin
        if (qb.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL b_spurious act=valid exp=idle t=%0t", $time);
        end else begin
          e = qb.pop_front();
          chk("b_out", {b_frame, b_idx, b_par}, {1'b1, e});
          lb = e[31:0];
        end
      end else begin
        chk("b_hold", {b_frame, b_par}, {1'b0, lb});
      end
    end
  end

  localparam logic [31:0] A0 = 32'h44332211;
  localparam logic [23:0] C0 = 24'h332211;

  initial begin
    #2 rst_n = 1'b0;
    #2 zero_chk("rst_init");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // continuous CCW streaming, serial 01..04
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b0, 1'b1, A0, C0, 8'(i % 4 + 1));
    // CW, direction toggled and data changed mid-frame
    for (int i = 0; i < 12; i++)
      drive(1'b1, 1'b0, (i % 4 >= 2), (i % 4 == 3) ? 32'hdeadbeef : A0,
            (i % 4 == 3) ? 24'h0badf0 : C0, 8'(i % 4 + 1));
    // gapped enables
    drive(1'b0, 1'b1, 1'b1, A0, C0, 8'h00);
    for (int i = 0; i < 7; i++)
      drive((i == 0 || i == 3 || i == 4 || i == 6), 1'b0, 1'b1, A0, C0,
            8'(i + 1));
    // sync discards a partial frame, then 05..08
    drive(1'b0, 1'b1, 1'b1, A0, C0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, A0, C0, 8'h0a);
    drive(1'b1, 1'b0, 1'b1, A0, C0, 8'h0b);
    drive(1'b1, 1'b1, 1'b1, A0, C0, 8'h0c);
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b0, 1'b1, A0, C0, 8'(i + 5));
    drive(1'b0, 1'b0, 1'b1, A0, C0, 8'h00);
    // reset mid-frame, then a CW frame
    drive(1'b1, 1'b0, 1'b1, A0, C0, 8'h11);
    drive(1'b1, 1'b0, 1'b1, A0, C0, 8'h12);
    do_reset();
    for (int i = 0; i < 6; i++)
      drive(1'b1, 1'b0, 1'b0, A0, C0, 8'(i + 1));

    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
            1'($urandom), $urandom, 24'($urandom), 8'($urandom));

    repeat (3) drive(1'b0, 1'b0, 1'b1, A0, C0, 8'h00);
    @(negedge clk);
    #1;
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    chk("qc_drained", 64'(qc.size()), 64'd0);
    chk("unused_outs", {a_ppar, c_ppar, b_oser}, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
